// File: rtl/uart_fifo_iface.sv
// UART register slave with power-of-two RX/TX FIFOs, sticky overflow/drop flags,
// an RX fill count and flush controls. Define UART_LOOPBACK_EN for internal loopback.

module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shreg_q, shreg_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      TX_IDLE:
        if (valid) begin
          shreg_d = {1'b1, data, 1'b0};
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_SEND;
        end
      TX_SEND:
        if (baud_q == CW'(CPB - 1)) begin
          baud_d  = '0;
          shreg_d = {1'b1, shreg_q[9:1]};
          if (bit_q == 4'd9) state_d = TX_IDLE;
          else               bit_d   = bit_q + 4'd1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      default: state_d = TX_IDLE;
    endcase
  end

  assign ready = (state_q == TX_IDLE);
  assign tx    = (state_q == TX_SEND) ? shreg_q[0] : 1'b1;
endmodule

module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          valid_q, valid_d;
  logic          rxs;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= '1;
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
    end

  // Start bit is re-checked at mid-bit; data and stop are sampled one bit apart from there.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = valid_q & ~ready;
    case (state_q)
      RX_IDLE: begin
        baud_d = '0;
        if (!rxs) state_d = RX_START;
      end
      RX_START:
        if (baud_q == CW'(CPB / 2 - 1)) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rxs ? RX_IDLE : RX_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      RX_DATA:
        if (baud_q == CW'(CPB - 1)) begin
          baud_d  = '0;
          shreg_d = {rxs, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      RX_STOP:
        if (baud_q == CW'(CPB - 1)) begin
          state_d = RX_IDLE;
          if (rxs) valid_d = 1'b1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      default: state_d = RX_IDLE;
    endcase
  end

  assign valid = valid_q;
  assign data  = shreg_q;
endmodule

module uart_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic [7:0]  wdata,
  input  logic        pop,
  output logic [7:0]  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        drop
);
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign count   = wr_q - rd_q;
  // A pop frees the slot, so a push at full still lands in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign drop    = push & ~flush & full & ~do_pop;
  assign rdata   = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      rd_q <= wr_q;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end

  always_ff @(posedge clk)
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
endmodule

module uart_fifo_iface #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int RX_DEPTH  = 16,
  parameter int TX_DEPTH  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        rx_i,
  output logic        tx_o
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  logic [1:0]       sel;
  logic             data_rd, data_wr, stat_rd, ctrl_wr, rx_flush, tx_flush;
  logic [7:0]       rx_head, tx_head, rx_byte;
  logic             rx_full, rx_empty, rx_ovf_ev, rx_valid;
  logic             tx_full, tx_empty, tx_drop_ev, tx_ready;
  logic [RX_AW:0]   rx_count;
  logic [TX_AW:0]   tx_count;
  logic             rx_ovf_q, tx_drop_q, rvalid_q, loopback, rx_line, tx_line;
  logic [31:0]      rdata_q, rdata_d;
  logic             unused_ok;

  assign sel      = addr_i[3:2];
  assign data_rd  = req_i & ~we_i & (sel == 2'd0);
  assign data_wr  = req_i &  we_i & (sel == 2'd0);
  assign stat_rd  = req_i & ~we_i & (sel == 2'd1);
  assign ctrl_wr  = req_i &  we_i & (sel == 2'd2);
  assign rx_flush = ctrl_wr & wdata_i[1];
  assign tx_flush = ctrl_wr & wdata_i[2];

  uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk_i), .rst_n(rst_ni), .flush(rx_flush), .push(rx_valid), .wdata(rx_byte),
    .pop(data_rd), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count),
    .drop(rx_ovf_ev)
  );

  uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk_i), .rst_n(rst_ni), .flush(tx_flush), .push(data_wr), .wdata(wdata_i[7:0]),
    .pop(tx_ready), .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count),
    .drop(tx_drop_ev)
  );

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
    .clk(clk_i), .rst_n(rst_ni), .data(tx_head), .valid(~tx_empty & ~tx_flush),
    .ready(tx_ready), .tx(tx_line)
  );

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
    .clk(clk_i), .rst_n(rst_ni), .rx(rx_line), .data(rx_byte), .valid(rx_valid),
    .ready(1'b1)
  );

`ifdef UART_LOOPBACK_EN
  logic loopback_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)      loopback_q <= 1'b0;
    else if (ctrl_wr) loopback_q <= wdata_i[0];
  assign loopback = loopback_q;
  assign rx_line  = loopback_q ? tx_line : rx_i;
  assign tx_o     = loopback_q | tx_line;
`else
  assign loopback = 1'b0;
  assign rx_line  = rx_i;
  assign tx_o     = tx_line;
`endif

  always_comb begin
    rdata_d = '0;
    case (sel)
      2'd0: rdata_d = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_head};
      2'd1: rdata_d = {8'h0, 8'(rx_count), 11'h0, tx_drop_q, rx_ovf_q,
                       tx_empty & tx_ready, ~rx_empty, tx_full};
      2'd2: rdata_d = {31'h0, loopback};
      default: rdata_d = '0;
    endcase
  end

  // New events win over a same-cycle STATUS clear so none is lost unseen.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rx_ovf_q  <= 1'b0;
      tx_drop_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rx_ovf_q  <= rx_ovf_ev  | (rx_ovf_q  & ~stat_rd);
      tx_drop_q <= tx_drop_ev | (tx_drop_q & ~stat_rd);
      rvalid_q  <= req_i;
      if (req_i) rdata_q <= we_i ? '0 : rdata_d;
    end

  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign unused_ok = ^{wdata_i[31:8], addr_i[1:0], tx_count, rx_full};
endmodule

// File: tb/tb_uart_fifo_iface.sv
// Randomized scoreboard bench for uart_fifo_iface: bus responses and decoded tx
// frames are checked against a queue-based model of the register/FIFO rules.
module tb_uart_fifo_iface;
  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int FRAME     = 10 * CPB;
  localparam int RX_DEPTH  = 4;
  localparam int TX_DEPTH  = 4;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, rx = 1'b1;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        rvalid, tx;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  uart_fifo_iface #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .rx_i(rx), .tx_o(tx)
  );

  typedef struct { logic [31:0] exp; bit chk; string nm; } rsp_t;
  rsp_t       exp_q[$];
  logic [7:0] rxq[$];
  logic [7:0] tx_exp[$];
  bit         m_ovf, m_drop, sb_bypass, tx_ignore;
  int         checks, passes;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] exp_status(input bit txf, input bit txi);
    return {8'h0, 8'(rxq.size()), 11'h0, m_drop, m_ovf, txi, rxq.size() != 0, txf};
  endfunction

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    rsp_t e;
    e.exp = '0; e.chk = 1'b0; e.nm = "wr";
    exp_q.push_back(e);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [31:0] x, input string nm);
    rsp_t e;
    e.exp = x; e.chk = 1'b1; e.nm = nm;
    exp_q.push_back(e);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic rd_data();
    logic [31:0] x;
    if (rxq.size() == 0) x = 32'hFFFF_FFFF;
    else                 x = {24'h0, rxq.pop_front()};
    bus_rd(4'h0, x, "data");
  endtask

  task automatic rd_status(input bit txf, input bit txi);
    logic [31:0] x;
    x = exp_status(txf, txi);
    m_ovf = 1'b0; m_drop = 1'b0;
    bus_rd(4'h4, x, "status");
  endtask

  task automatic drive_rx(input logic [7:0] b);
    rx = 1'b0; repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; repeat (CPB) @(negedge clk);
    end
    rx = 1'b1; repeat (CPB) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] b);
    drive_rx(b);
    repeat (4) @(negedge clk);
    if (rxq.size() < RX_DEPTH) rxq.push_back(b);
    else m_ovf = 1'b1;
  endtask

  // Bus response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rvalid && !sb_bypass) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL rsp_unexpected: got rdata %h with no request outstanding", rdata);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) chk(e.nm, rdata, e.exp);
        end
      end
    end
  end

  // Serial line decoder for tx
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (!tx_ignore) begin
          chk("tx_stop", 32'(tx), 32'd1);
          if (tx_exp.size() == 0) begin
            checks++;
            $display("FAIL tx_unexpected: got byte %h with none queued", b);
          end else chk("tx_byte", {24'h0, b}, {24'h0, tx_exp.pop_front()});
        end
      end
    end
  end

  initial begin
    int n, found, p_off, lowcnt;
    logic [7:0] bs [8];
    logic [7:0] nb;

    repeat (3) @(negedge clk);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_tx", 32'(tx), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    rd_status(1'b0, 1'b1);
    rd_data();
    bus_rd(4'hC, 32'd0, "reg_c");
    bus_rd(4'h8, 32'd0, "ctrl");

    bus_wr(4'h0, 32'h41); bus_wr(4'h0, 32'h42); bus_wr(4'h0, 32'h43);
    tx_exp.push_back(8'h41); tx_exp.push_back(8'h42); tx_exp.push_back(8'h43);
    repeat (3 * FRAME + 20) @(negedge clk);
    rd_status(1'b0, 1'b1);

    // Serialiser holds one byte and the FIFO the next TX_DEPTH; the rest drop.
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? 6 : int'($urandom_range(1, 7));
      for (int k = 0; k < n; k++) begin
        bs[k] = 8'($urandom);
        bus_wr(4'h0, {24'h0, bs[k]});
        if (k <= TX_DEPTH) tx_exp.push_back(bs[k]);
        else m_drop = 1'b1;
      end
      rd_status(n > TX_DEPTH, 1'b0);
      rd_status(n > TX_DEPTH, 1'b0);
      repeat (((n > TX_DEPTH + 1) ? TX_DEPTH + 1 : n) * FRAME + 20) @(negedge clk);
      rd_status(1'b0, 1'b1);
    end

    for (int i = 0; i < RX_DEPTH + 2; i++) rx_frame(8'($urandom));
    rd_status(1'b0, 1'b1);
    rd_status(1'b0, 1'b1);
    for (int i = 0; i < RX_DEPTH + 1; i++) rd_data();

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 2))
        0:       rx_frame(8'($urandom));
        1:       rd_data();
        default: rd_status(1'b0, 1'b1);
      endcase
    end

    // Find the cycle offset at which a received byte lands, then hit it with a pop at full.
    rd_status(1'b0, 1'b1);
    while (rxq.size() != 0) rd_data();
    repeat (2) @(negedge clk);
    found = -1;
    fork
      drive_rx(8'hC3);
      begin
        sb_bypass = 1'b1; req = 1'b1; we = 1'b0; addr = 4'h4;
        for (int c = 1; c <= FRAME; c++) begin
          @(negedge clk);
          if (found < 0 && rvalid && rdata[1]) found = c;
        end
        req = 1'b0;
        repeat (2) @(negedge clk);
        sb_bypass = 1'b0;
      end
    join
    chk("rx_arrival_seen", 32'(found > 2), 32'd1);
    p_off = (found > 2) ? found - 2 : 0;
    m_ovf = 1'b0; m_drop = 1'b0;
    rxq.push_back(8'hC3);
    while (rxq.size() < RX_DEPTH) rx_frame(8'($urandom));
    nb = 8'($urandom);
    fork
      drive_rx(nb);
      begin
        repeat (p_off) @(negedge clk);
        rd_data();
      end
    join
    rxq.push_back(nb);
    repeat (4) @(negedge clk);
    rd_status(1'b0, 1'b1);
    for (int i = 0; i < RX_DEPTH + 1; i++) rd_data();

    rx_frame(8'($urandom)); rx_frame(8'($urandom));
    bus_wr(4'h8, 32'h2);
    rxq.delete();
    rd_status(1'b0, 1'b1);
    rd_data();

    for (int k = 0; k < 6; k++) begin
      bs[k] = 8'($urandom);
      bus_wr(4'h0, {24'h0, bs[k]});
    end
    tx_exp.push_back(bs[0]);
    m_drop = 1'b1;
    bus_wr(4'h8, 32'h4);
    repeat (FRAME + 40) @(negedge clk);
    rd_status(1'b0, 1'b1);

`ifdef UART_LOOPBACK_EN
    bus_wr(4'h8, 32'h1);
    bus_rd(4'h8, 32'h1, "ctrl_lb");
    lowcnt = 0;
    bus_wr(4'h0, 32'h5A);
    bus_wr(4'h0, 32'hA5);
    for (int c = 0; c < 2 * FRAME + 40; c++) begin
      @(negedge clk);
      if (!tx) lowcnt++;
    end
    chk("lb_tx_held", 32'(lowcnt), 32'd0);
    rxq.push_back(8'h5A); rxq.push_back(8'hA5);
    rd_data();
    bus_wr(4'h8, 32'h2);
    rxq.delete();
    rd_status(1'b0, 1'b1);
    bus_rd(4'h8, 32'h0, "ctrl_lb_off");
`else
    lowcnt = 0;
    bus_wr(4'h8, 32'h1);
    bus_rd(4'h8, 32'h0, "ctrl_nolb");
    bus_wr(4'h8, 32'h0);
`endif

    rx_frame(8'($urandom));
    bus_wr(4'h0, 32'h99);
    tx_ignore = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", 32'(tx), 32'd1);
    repeat (3) @(negedge clk);
    chk("midframe_reset_rvalid", 32'(rvalid), 32'd0);
    rst_n = 1'b1;
    rxq.delete();
    m_ovf = 1'b0; m_drop = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    tx_ignore = 1'b0;
    rd_status(1'b0, 1'b1);
    rd_data();

    repeat (4) @(negedge clk);
    chk("rsp_outstanding", 32'(exp_q.size()), 32'd0);
    chk("tx_pending", 32'(tx_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
